// File: rtl/ls_buffer_pkg.sv
// -----------------------------------------------------------------------------
// pkg_structures
//
// Shared types for the load/store buffer:
//   instr_name_e  - memory instruction mnemonic carried with every entry
//   ls_entry_t    - one queue entry (instruction, two operands, immediate, tag)
//   ls_state_e    - sequencing states of the ls_buffer controller
//
// LS_TAG_WIDTH is the tag width stored inside an entry. ls_buffer casts its
// TAG_WIDTH port onto this field, so a wider TAG_WIDTH also needs this
// constant raised to match.
// -----------------------------------------------------------------------------
package pkg_structures;

  localparam int LS_TAG_WIDTH = 6;

  typedef enum logic [3:0] {
    INSTR_LB  = 4'd0,
    INSTR_LH  = 4'd1,
    INSTR_LW  = 4'd2,
    INSTR_LBU = 4'd3,
    INSTR_LHU = 4'd4,
    INSTR_SB  = 4'd5,
    INSTR_SH  = 4'd6,
    INSTR_SW  = 4'd7
  } instr_name_e;

  typedef struct packed {
    instr_name_e               instr_name;
    logic [31:0]               data_1;
    logic [31:0]               data_2;
    logic [31:0]               immediate;
    logic [LS_TAG_WIDTH-1:0]   tag;
  } ls_entry_t;

  typedef enum logic [1:0] {
    LS_IDLE   = 2'd0,
    LS_EXEC   = 2'd1,
    LS_RESULT = 2'd2
  } ls_state_e;

endpackage : pkg_structures

// File: rtl/ls_buffer_fifo.sv
// -----------------------------------------------------------------------------
// ls_fifo
//
// Circular entry store for the load/store buffer. Head/tail pointers wrap
// modulo DEPTH (DEPTH is a power of two, so plain binary overflow does the
// wrap); the occupancy counter is one bit wider so "full" is representable.
// Storage is deliberately not reset: only pointers and count are cleared.
//
// Ports
//   clk       in   clock, rising edge
//   reset_n   in   asynchronous active-low reset (pointers/count only)
//   clear_i   in   synchronous clear of pointers/count; overrides push/pop
//   push_i    in   write wdata_i at tail (ignored when full)
//   pop_i     in   retire the head entry (ignored when empty)
//   wdata_i   in   entry to write
//   rdata_o   out  entry at head (valid when count_o != 0)
//   count_o   out  registered occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module ls_fifo
  import pkg_structures::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  ls_entry_t                wdata_i,
  output ls_entry_t                rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  ls_entry_t mem_q [DEPTH];

  // Guards live here as well as in the caller so the FIFO can never
  // overrun or underrun regardless of how it is driven.
  assign push_ok = push_i && (count_q < DEPTH_C) && !clear_i;
  assign pop_ok  = pop_i && (count_q != '0) && !clear_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) tail_d = tail_q + PTR_W'(1);
      if (pop_ok)  head_d = head_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[tail_q] <= wdata_i;
  end

  assign rdata_o = mem_q[head_q];
  assign count_o = count_q;

endmodule : ls_fifo

// File: rtl/ls_buffer.sv
// -----------------------------------------------------------------------------
// ls_buffer
//
// In-order load/store buffer. Dispatch pushes memory ops into ls_fifo; a
// three-state controller presents the head op to the load/store execution
// unit, captures its result and holds it on the result broadcast until the
// consumer acknowledges. Only one op is in flight at a time.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   LS_IDLE   | nothing presented; move to LS_EXEC once the queue is non-empty
//   LS_EXEC   | head op on exu_*; exu_done pops it and latches the result
//   LS_RESULT | result_* broadcast held until result_ack
//
// Optional build macro: LS_BUFFER_FLUSH_EN adds input `flush` (mispredict
// recovery). A flush empties the queue, returns the controller to LS_IDLE,
// drops any same-cycle enqueue and overrides exu_done/result_ack.
//
// Ports
//   clk, reset_n                  clock / asynchronous active-low reset
//   flush                         (LS_BUFFER_FLUSH_EN only) synchronous flush
//   in_valid / in_ready           dispatch handshake; in_ready = count < DEPTH
//   in_instr_name, in_data_1/2,
//   in_immediate, in_tag          entry payload
//   exu_valid, exu_instr_name,
//   exu_data_1/2, exu_immediate   head op to the execution unit
//   exu_done, exu_result          execution-unit completion and result data
//   result_valid/tag/data         completion broadcast
//   result_ack                    consumer takes the broadcast
// -----------------------------------------------------------------------------
module ls_buffer
  import pkg_structures::*;
#(
  parameter int DEPTH     = 8,
  parameter int TAG_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
`ifdef LS_BUFFER_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  in_valid,
  output logic                  in_ready,
  input  instr_name_e           in_instr_name,
  input  logic [31:0]           in_data_1,
  input  logic [31:0]           in_data_2,
  input  logic [31:0]           in_immediate,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  exu_valid,
  output instr_name_e           exu_instr_name,
  output logic [31:0]           exu_data_1,
  output logic [31:0]           exu_data_2,
  output logic [31:0]           exu_immediate,
  input  logic                  exu_done,
  input  logic [31:0]           exu_result,
  output logic                  result_valid,
  output logic [TAG_WIDTH-1:0]  result_tag,
  output logic [31:0]           result_data,
  input  logic                  result_ack
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  ls_state_e             state_q, state_d;
  logic [TAG_WIDTH-1:0]  result_tag_q, result_tag_d;
  logic [31:0]           result_data_q, result_data_d;

  ls_entry_t             in_entry;
  ls_entry_t             head_entry;
  logic [CNT_W-1:0]      fifo_count;
  logic                  push;
  logic                  pop;
  logic                  flush_w;

`ifdef LS_BUFFER_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  always_comb begin
    in_entry            = '0;
    in_entry.instr_name = in_instr_name;
    in_entry.data_1     = in_data_1;
    in_entry.data_2     = in_data_2;
    in_entry.immediate  = in_immediate;
    in_entry.tag        = LS_TAG_WIDTH'(in_tag);
  end

  // in_ready comes straight off the registered count: a pop in the same
  // cycle does not open a slot until the next edge.
  assign in_ready = (fifo_count < DEPTH_C);
  assign push     = in_valid && in_ready && !flush_w;

  ls_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (flush_w),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_entry),
    .rdata_o (head_entry),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    result_tag_d  = result_tag_q;
    result_data_d = result_data_q;
    case (state_q)
      LS_IDLE: begin
        if (fifo_count != '0) state_d = LS_EXEC;
      end
      LS_EXEC: begin
        if (exu_done) begin
          pop           = 1'b1;
          result_tag_d  = TAG_WIDTH'(head_entry.tag);
          result_data_d = exu_result;
          state_d       = LS_RESULT;
        end
      end
      LS_RESULT: begin
        if (result_ack) state_d = LS_IDLE;
      end
      default: state_d = LS_IDLE;
    endcase
    // Flush wins over completion and acknowledge; the result registers keep
    // their contents but are no longer broadcast once back in LS_IDLE.
    if (flush_w) begin
      state_d = LS_IDLE;
      pop     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= LS_IDLE;
      result_tag_q  <= '0;
      result_data_q <= '0;
    end else begin
      state_q       <= state_d;
      result_tag_q  <= result_tag_d;
      result_data_q <= result_data_d;
    end
  end

  assign exu_valid      = (state_q == LS_EXEC);
  assign exu_instr_name = head_entry.instr_name;
  assign exu_data_1     = head_entry.data_1;
  assign exu_data_2     = head_entry.data_2;
  assign exu_immediate  = head_entry.immediate;

  assign result_valid   = (state_q == LS_RESULT);
  assign result_tag     = result_tag_q;
  assign result_data    = result_data_q;

endmodule : ls_buffer

// File: tb/tb_ls_buffer.sv
module tb_ls_buffer;
  import pkg_structures::*;

  localparam int DEPTH = 8;
  localparam int TW    = 6;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
`ifdef LS_BUFFER_FLUSH_EN
  logic              flush = 1'b0;
`endif
  logic              in_valid = 1'b0;
  logic              in_ready;
  instr_name_e       in_instr_name = INSTR_LW;
  logic [31:0]       in_data_1 = '0, in_data_2 = '0, in_immediate = '0;
  logic [TW-1:0]     in_tag = '0;
  logic              exu_valid;
  instr_name_e       exu_instr_name;
  logic [31:0]       exu_data_1, exu_data_2, exu_immediate;
  logic              exu_done = 1'b0;
  logic [31:0]       exu_result = '0;
  logic              result_valid;
  logic [TW-1:0]     result_tag;
  logic [31:0]       result_data;
  logic              result_ack = 1'b0;

  ls_buffer #(.DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
`ifdef LS_BUFFER_FLUSH_EN
    .flush          (flush),
`endif
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr_name  (in_instr_name),
    .in_data_1      (in_data_1),
    .in_data_2      (in_data_2),
    .in_immediate   (in_immediate),
    .in_tag         (in_tag),
    .exu_valid      (exu_valid),
    .exu_instr_name (exu_instr_name),
    .exu_data_1     (exu_data_1),
    .exu_data_2     (exu_data_2),
    .exu_immediate  (exu_immediate),
    .exu_done       (exu_done),
    .exu_result     (exu_result),
    .result_valid   (result_valid),
    .result_tag     (result_tag),
    .result_data    (result_data),
    .result_ack     (result_ack)
  );

  always #5 clk = ~clk;

  // Reference model: program-order queue of accepted ops plus a queue of
  // results awaiting acknowledge.
  typedef struct packed {
    logic [TW-1:0] tag;
    logic [31:0]   data;
  } res_t;

  ls_entry_t     mq[$];
  res_t          rq[$];
  logic [TW-1:0] ack_log[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            stall    = 0;
  int            retired  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic ls_entry_t rand_op(input logic [TW-1:0] tag);
    ls_entry_t o;
    o.instr_name = instr_name_e'(4'($urandom_range(0, 7)));
    o.data_1     = $urandom;
    o.data_2     = $urandom;
    o.immediate  = $urandom;
    o.tag        = tag;
    return o;
  endfunction

  task automatic observe();
    check("in_ready", in_ready, mq.size() < DEPTH);
    check("result_valid", result_valid, rq.size() > 0);
    if (result_valid && rq.size() > 0) begin
      check("result_tag", result_tag, rq[0].tag);
      check("result_data", result_data, rq[0].data);
    end
    if (exu_valid) begin
      check("exu_allowed", (mq.size() > 0 && rq.size() == 0), 1);
      if (mq.size() > 0) begin
        check("exu_instr", exu_instr_name, mq[0].instr_name);
        check("exu_data_1", exu_data_1, mq[0].data_1);
        check("exu_data_2", exu_data_2, mq[0].data_2);
        check("exu_imm", exu_immediate, mq[0].immediate);
      end
    end
    // Pending work with nothing in flight may idle for at most one cycle.
    if (!exu_valid && mq.size() > 0 && rq.size() == 0) stall++;
    else stall = 0;
    check("exu_latency", stall <= 1, 1);
  endtask

  // Called at a negedge: drive inputs for the coming posedge, advance the
  // model by what that edge will do, then observe at the following negedge.
  task automatic cycle(input logic iv, input ls_entry_t p, input logic dn,
                       input logic [31:0] res, input logic ak, input logic fl);
    bit acc;
    in_valid      = iv;
    in_instr_name = p.instr_name;
    in_data_1     = p.data_1;
    in_data_2     = p.data_2;
    in_immediate  = p.immediate;
    in_tag        = p.tag;
    exu_done      = dn;
    exu_result    = res;
    result_ack    = ak;
`ifdef LS_BUFFER_FLUSH_EN
    flush         = fl;
`endif
    if (fl) begin
      mq.delete();
      rq.delete();
    end else begin
      acc = iv && (mq.size() < DEPTH);
      if (exu_valid && dn && mq.size() > 0) begin
        rq.push_back('{tag: mq[0].tag, data: res});
        void'(mq.pop_front());
      end
      if (result_valid && ak && rq.size() > 0) begin
        ack_log.push_back(result_tag);
        retired++;
        void'(rq.pop_front());
      end
      if (acc) mq.push_back(p);
    end
    @(negedge clk);
    observe();
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic wait_exu();
    for (int i = 0; i < 6 && !exu_valid; i++) idle();
    check("wait_exu", exu_valid, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (mq.size() > 0 || rq.size() > 0); i++)
      cycle(1'b0, '0, 1'b1, $urandom, 1'b1, 1'b0);
    check("drain_empty", mq.size() + rq.size(), 0);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    exu_done   = 1'b0;
    result_ack = 1'b0;
`ifdef LS_BUFFER_FLUSH_EN
    flush      = 1'b0;
`endif
    mq.delete();
    rq.delete();
    stall = 0;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_exu_valid", exu_valid, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result_tag", result_tag, 0);
    check("rst_result_data", result_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    observe();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ls_entry_t op;
    int        r0;
    int        t;

    // Reset state and single LW
    do_reset();
    op = '{instr_name: INSTR_LW, data_1: 32'h100, data_2: 32'h0, immediate: 32'h4, tag: 6'd3};
    cycle(1'b1, op, 1'b0, 32'h0, 1'b0, 1'b0);
    check("lw_exu_at_N", exu_valid, 0);
    idle();
    check("lw_exu_at_N1", exu_valid, 1);
    check("lw_data_1", exu_data_1, 32'h100);
    check("lw_imm", exu_immediate, 32'h4);
    cycle(1'b0, '0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    check("lw_result_valid", result_valid, 1);
    check("lw_result_tag", result_tag, 3);
    check("lw_result_data", result_data, 32'hDEADBEEF);

    // Backpressure: ack low 5 cycles, enqueues continue, stray exu_done ignored
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, rand_op(6'(10 + i)), 1'b1, $urandom, 1'b0, 1'b0);
      check("bp_tag_hold", result_tag, 3);
      check("bp_data_hold", result_data, 32'hDEADBEEF);
      check("bp_no_exu", exu_valid, 0);
    end
    check("bp_queued", mq.size(), 5);
    cycle(1'b0, '0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("bp_ack_drop", result_valid, 0);
    drain();

    // Fill: 8 enqueues with no completion, 9th ignored
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, rand_op(6'(i)), 1'b0, 32'h0, 1'b0, 1'b0);
    check("fill_full", in_ready, 0);
    cycle(1'b1, rand_op(6'd63), 1'b0, 32'h0, 1'b0, 1'b0);
    check("fill_still_full", in_ready, 0);
    r0 = retired;
    drain();
    check("fill_results", retired - r0, DEPTH);

    // Order and wrap: 12 ops, interleaved enqueue/pop
    do_reset();
    ack_log.delete();
    t = 0;
    for (int i = 0; i < 300 && ack_log.size() < 12; i++) begin
      if (t < 12 && $urandom_range(0, 2) != 0 && mq.size() < DEPTH) begin
        cycle(1'b1, rand_op(6'(t)), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
        t++;
      end else begin
        cycle(1'b0, '0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
      end
    end
    check("order_count", ack_log.size(), 12);
    for (int i = 0; i < ack_log.size(); i++) check("order_tag", ack_log[i], 6'(i));

    // Reset mid-EXEC with 3 queued
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_op(6'(20 + i)), 1'b0, 32'h0, 1'b0, 1'b0);
    wait_exu();
    #2;
    reset_n = 1'b0;
    #1;
    mq.delete();
    rq.delete();
    stall = 0;
    check("mid_rst_exu", exu_valid, 0);
    check("mid_rst_result", result_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    check("mid_rst_next_exu", exu_valid, 0);
    check("mid_rst_next_ready", in_ready, 1);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      check("mid_rst_quiet", exu_valid, 0);
    end

`ifdef LS_BUFFER_FLUSH_EN
    // Flush during RESULT with 4 queued plus a same-cycle enqueue
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, rand_op(6'(30 + i)), 1'b0, 32'h0, 1'b0, 1'b0);
    wait_exu();
    cycle(1'b0, '0, 1'b1, 32'h12345678, 1'b0, 1'b0);
    check("fl_in_result", result_valid, 1);
    cycle(1'b1, rand_op(6'd40), 1'b0, 32'h0, 1'b1, 1'b1);
    check("fl_result_drop", result_valid, 0);
    check("fl_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("fl_no_exu", exu_valid, 0);
    end
`endif

    // Randomized traffic
    do_reset();
    t = 0;
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(0, 1)), rand_op(6'(t)), 1'($urandom_range(0, 2) == 0),
            $urandom, 1'($urandom_range(0, 1)), 1'b0);
      t++;
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_ls_buffer
